// File: rtl/trigger_seq_ctrl.sv
// trigger_seq_ctrl: shot sequencer arming the pulse-TOF trigger generator and queueing results in a FWFT FIFO.
// Define TRIG_SEQ_TSTAMP_EN to store a free-running rxclk timestamp beside each result.
module trigger_seq_ctrl #(
    parameter int SHOTS_W = 8,
    parameter int FIFO_AW = 3
) (
    input  logic               rxclk,
    input  logic               resetn,
    input  logic               ctrl_start,
    input  logic               ctrl_abort,
    input  logic [SHOTS_W-1:0] cfg_shots,
    input  logic [31:0]        cfg_timeout,
    input  logic [31:0]        cfg_holdoff,
    input  logic               detect_pls_1,
    input  logic [31:0]        pulse_tof,
    output logic               trig_enable,
    output logic               busy,
    output logic               done_irq,
    output logic               tmo_irq,
    output logic [15:0]        tmo_count,
    output logic               ovf,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_data,
    output logic [31:0]        res_tstamp,
    output logic [FIFO_AW:0]   res_count
);

    localparam int DEPTH = 1 << FIFO_AW;
`ifdef TRIG_SEQ_TSTAMP_EN
    localparam int FW = 64;
`else
    localparam int FW = 32;
`endif

    typedef enum logic [2:0] {IDLE, ARM, RUN, CAPTURE, HOLDOFF, DONE} state_t;

    state_t             state, state_d;
    logic               det_q;
    logic [SHOTS_W-1:0] shots_l, shot_cnt, shot_nx;
    logic [31:0]        tmo_l, hold_l, tmo_cnt, hold_cnt, cap_tof;
    logic               shot_done, tmo_exp, start_ok, push, pop, full;
    logic [FW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0]      wdata, head;

    assign shot_done   = state == RUN && det_q && !detect_pls_1;
    // a shot completing on the expiry cycle takes precedence over the timeout
    assign tmo_exp     = state == RUN && !shot_done && tmo_l != 32'd0 && tmo_cnt <= 32'd1;
    assign start_ok    = state == IDLE && ctrl_start && !ctrl_abort;
    assign shot_nx     = shot_cnt + SHOTS_W'(1);
    assign trig_enable = state == RUN || state == CAPTURE;
    assign busy        = state != IDLE;
    assign done_irq    = state == DONE;
    assign res_valid   = res_count != '0;
    assign full        = res_count == (FIFO_AW+1)'(DEPTH);
    assign pop         = res_valid && res_ready;
    // when full, a simultaneous pop frees the slot the push lands in
    assign push        = state == CAPTURE && !ctrl_abort && (!full || pop);
    assign head        = mem[rd_ptr];
    assign res_data    = head[31:0];

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = ctrl_start ? ARM : IDLE;
            ARM:     state_d = RUN;
            RUN:     state_d = shot_done ? CAPTURE : tmo_exp ? HOLDOFF : RUN;
            CAPTURE: state_d = (shots_l != '0 && shot_nx == shots_l) ? DONE : HOLDOFF;
            HOLDOFF: state_d = hold_cnt <= 32'd1 ? RUN : HOLDOFF;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ctrl_abort) state_d = IDLE;
    end

    always_ff @(posedge rxclk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            det_q     <= 1'b0;
            shots_l   <= '0;
            shot_cnt  <= '0;
            tmo_l     <= '0;
            hold_l    <= '0;
            tmo_cnt   <= '0;
            hold_cnt  <= '0;
            cap_tof   <= '0;
            tmo_irq   <= 1'b0;
            tmo_count <= '0;
            ovf       <= 1'b0;
        end else begin
            state   <= state_d;
            det_q   <= detect_pls_1;
            tmo_irq <= tmo_exp && !ctrl_abort;
            if (start_ok) begin
                shots_l   <= cfg_shots;
                tmo_l     <= cfg_timeout;
                hold_l    <= cfg_holdoff;
                shot_cnt  <= '0;
                tmo_count <= '0;
                ovf       <= 1'b0;
            end
            if (state == CAPTURE) shot_cnt <= shot_nx;
            if (state_d == RUN && state != RUN) tmo_cnt <= tmo_l;
            else if (state == RUN) tmo_cnt <= tmo_cnt - 32'd1;
            if (state_d == HOLDOFF && state != HOLDOFF) hold_cnt <= hold_l == 32'd0 ? 32'd1 : hold_l;
            else if (state == HOLDOFF) hold_cnt <= hold_cnt - 32'd1;
            if (tmo_exp && !ctrl_abort && tmo_count != 16'hFFFF) tmo_count <= tmo_count + 16'd1;
            if (shot_done) cap_tof <= pulse_tof;
            if (state == CAPTURE && !ctrl_abort && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge rxclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            res_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            res_count <= res_count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    always_ff @(posedge rxclk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

`ifdef TRIG_SEQ_TSTAMP_EN
    logic [31:0] ts_cnt, cap_ts;

    always_ff @(posedge rxclk or negedge resetn) begin
        if (!resetn) begin
            ts_cnt <= '0;
            cap_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (shot_done) cap_ts <= ts_cnt;
        end
    end

    assign wdata      = {cap_ts, cap_tof};
    assign res_tstamp = head[63:32];
`else
    assign wdata      = cap_tof;
    assign res_tstamp = 32'h0;
`endif

endmodule
